// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide responder: op encodings,
// FSM state encoding and the HI/LO result pair.
package md_unit_pkg;

  localparam int unsigned XALUOP_SIZE = 3;
  localparam int unsigned START_SIZE  = 1;
  localparam int unsigned DATA_W      = 32;

  localparam logic [XALUOP_SIZE-1:0] XALU_MULT  = 3'd0;
  localparam logic [XALUOP_SIZE-1:0] XALU_MULTU = 3'd1;
  localparam logic [XALUOP_SIZE-1:0] XALU_DIV   = 3'd2;
  localparam logic [XALUOP_SIZE-1:0] XALU_DIVU  = 3'd3;
  localparam logic [XALUOP_SIZE-1:0] XALU_MTHI  = 3'd4;
  localparam logic [XALUOP_SIZE-1:0] XALU_MTLO  = 3'd5;
  localparam logic [XALUOP_SIZE-1:0] XALU_MFHI  = 3'd6;
  localparam logic [XALUOP_SIZE-1:0] XALU_MFLO  = 3'd7;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_pair_t;

  // Ops 0..3 are the multi-cycle multiply/divide group.
  function automatic logic is_muldiv(input logic [XALUOP_SIZE-1:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_if.sv
// Datapath <-> md_unit bus.
// master (datapath): drives start/xaluop/a/b, observes busy/hi/lo/out.
// slave  (md_unit) : the reverse.
interface md_if;
  import md_unit_pkg::*;

  logic [START_SIZE-1:0]  start;
  logic [XALUOP_SIZE-1:0] xaluop;
  logic [DATA_W-1:0]      a;
  logic [DATA_W-1:0]      b;
  logic                   busy;
  logic [DATA_W-1:0]      hi;
  logic [DATA_W-1:0]      lo;
  logic [DATA_W-1:0]      out;

  modport master (output start, xaluop, a, b, input busy, hi, lo, out);
  modport slave  (input start, xaluop, a, b, output busy, hi, lo, out);

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// op       : xaluop code (only 0..3 produce a result)
// a, b     : operands
// res_hi/lo: {hi,lo} result for the op
// div_zero : DIV/DIVU with b == 0
module md_arith
  import md_unit_pkg::*;
(
  input  logic [XALUOP_SIZE-1:0] op,
  input  logic [DATA_W-1:0]      a,
  input  logic [DATA_W-1:0]      b,
  output logic [DATA_W-1:0]      res_hi,
  output logic [DATA_W-1:0]      res_lo,
  output logic                   div_zero
);

  logic                  is_signed;
  logic                  neg_a;
  logic                  neg_b;
  logic [DATA_W-1:0]     mag_a;
  logic [DATA_W-1:0]     mag_b;
  logic [DATA_W-1:0]     dvsr;
  logic [DATA_W-1:0]     uq;
  logic [DATA_W-1:0]     ur;
  logic [2*DATA_W-1:0]   prod;

  // Signed ops are done on magnitudes and the sign reapplied, so one
  // unsigned multiplier/divider serves both flavours and -2^31/-1 wraps
  // naturally to 0x80000000 with remainder 0.
  always_comb begin
    is_signed = (op == XALU_MULT) || (op == XALU_DIV);
    neg_a     = is_signed & a[DATA_W-1];
    neg_b     = is_signed & b[DATA_W-1];
    mag_a     = neg_a ? -a : a;
    mag_b     = neg_b ? -b : b;
    // Divisor forced nonzero; the zero case is discarded by the caller.
    dvsr      = (mag_b == '0) ? DATA_W'(1) : mag_b;
    uq        = mag_a / dvsr;
    ur        = mag_a % dvsr;
    prod      = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
    if (neg_a ^ neg_b) prod = -prod;

    res_hi = '0;
    res_lo = '0;
    if (op == XALU_MULT || op == XALU_MULTU) begin
      res_hi = prod[2*DATA_W-1:DATA_W];
      res_lo = prod[DATA_W-1:0];
    end else if (op == XALU_DIV || op == XALU_DIVU) begin
      res_lo = (neg_a ^ neg_b) ? -uq : uq;
      res_hi = neg_a ? -ur : ur;
    end

    div_zero = (op == XALU_DIV || op == XALU_DIVU) && (b == '0);
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide responder owning HI/LO.
// clk, reset (async, active-high)
// md : slave side of md_if (start/xaluop/a/b in; busy/hi/lo/out out)
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  localparam int unsigned MAX_CYCLES =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  md_pair_t          shadow;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              div_zero;

  md_arith u_arith (
    .op       (md.xaluop),
    .a        (md.a),
    .b        (md.b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // FSM, counter and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      shadow <= '0;
    end else if (state == MD_IDLE) begin
      if (md.start[0]) begin
        if (is_muldiv(md.xaluop)) begin
          // Divide by zero commits the current HI/LO back unchanged.
          shadow <= div_zero ? md_pair_t'({hi_q, lo_q})
                             : md_pair_t'({res_hi, res_lo});
          cnt    <= md.xaluop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          busy_q <= 1'b1;
          state  <= MD_BUSY;
        end else if (md.xaluop == XALU_MTHI) begin
          hi_q <= md.a;
        end else if (md.xaluop == XALU_MTLO) begin
          lo_q <= md.a;
        end
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        hi_q   <= shadow.hi;
        lo_q   <= shadow.lo;
        busy_q <= 1'b0;
        state  <= MD_IDLE;
      end
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  // Read port: no forwarding of in-flight results.
  always_comb begin
    md.out = '0;
    if (md.xaluop == XALU_MFHI)      md.out = hi_q;
    else if (md.xaluop == XALU_MFLO) md.out = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed table-driven bench for md_unit plus reset/under-stall sequences.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic allow_understall = 1'b0;

  always #5 clk = ~clk;

  md_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t        vecs [14];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  // The controller must never issue start while busy.
  always @(posedge clk) begin
    if (!reset && !allow_understall)
      assert (!(bus.busy && bus.start[0]))
        else $error("FAIL understall: start seen while busy");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request at the current negedge; return at the first idle negedge.
  task automatic run_op(input vec_t v, input int idx);
    int n;
    bus.start  = 1'b1;
    bus.xaluop = v.op;
    bus.a      = v.a;
    bus.b      = v.b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~v.a;
    bus.b     = v.b ^ 32'h0000_0005;
    if (v.cyc != 0) begin
      chk($sformatf("v%0d hi_hold", idx), bus.hi, prev_hi);
      chk($sformatf("v%0d lo_hold", idx), bus.lo, prev_lo);
    end
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(v.cyc));
    chk($sformatf("v%0d hi", idx), bus.hi, v.hi);
    chk($sformatf("v%0d lo", idx), bus.lo, v.lo);
    bus.xaluop = XALU_MFHI;
    #1 chk($sformatf("v%0d out_mfhi", idx), bus.out, v.hi);
    bus.xaluop = XALU_MFLO;
    #1 chk($sformatf("v%0d out_mflo", idx), bus.out, v.lo);
    bus.xaluop = XALU_DIVU;
    #1 chk($sformatf("v%0d out_other", idx), bus.out, 32'h0);
    prev_hi = v.hi;
    prev_lo = v.lo;
  endtask

  initial begin
    int n;
    vecs[0]  = '{op: XALU_MTLO,  a: 32'h0000AAAA, b: 32'h0,        hi: 32'h00000000, lo: 32'h0000AAAA, cyc: 0};
    vecs[1]  = '{op: XALU_MTHI,  a: 32'h12345678, b: 32'h0,        hi: 32'h12345678, lo: 32'h0000AAAA, cyc: 0};
    vecs[2]  = '{op: XALU_DIV,   a: 32'h00000005, b: 32'h0,        hi: 32'h12345678, lo: 32'h0000AAAA, cyc: 10};
    vecs[3]  = '{op: XALU_MULT,  a: 32'hFFFFFFFE, b: 32'h3,        hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA, cyc: 5};
    vecs[4]  = '{op: XALU_MULTU, a: 32'hFFFFFFFE, b: 32'h3,        hi: 32'h00000002, lo: 32'hFFFFFFFA, cyc: 5};
    vecs[5]  = '{op: XALU_DIV,   a: 32'hFFFFFFF9, b: 32'h2,        hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, cyc: 10};
    vecs[6]  = '{op: XALU_DIVU,  a: 32'h00000007, b: 32'h2,        hi: 32'h00000001, lo: 32'h00000003, cyc: 10};
    vecs[7]  = '{op: XALU_DIV,   a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000, cyc: 10};
    vecs[8]  = '{op: XALU_DIV,   a: 32'h00000007, b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD, cyc: 10};
    vecs[9]  = '{op: XALU_MULT,  a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000, cyc: 5};
    vecs[10] = '{op: XALU_MULTU, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001, cyc: 5};
    vecs[11] = '{op: XALU_DIVU,  a: 32'hFFFFFFFF, b: 32'h0000000A, hi: 32'h00000005, lo: 32'h19999999, cyc: 10};
    vecs[12] = '{op: XALU_DIVU,  a: 32'h00000005, b: 32'h0,        hi: 32'h00000005, lo: 32'h19999999, cyc: 10};
    vecs[13] = '{op: XALU_MFHI,  a: 32'hDEADBEEF, b: 32'h1,        hi: 32'h00000005, lo: 32'h19999999, cyc: 0};

    reset      = 1'b1;
    bus.start  = '0;
    bus.xaluop = XALU_MFHI;
    bus.a      = '0;
    bus.b      = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'h0);
    chk("rst hi", bus.hi, 32'h0);
    chk("rst lo", bus.lo, 32'h0);
    chk("rst out", bus.out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Requests run back to back: each starts the first idle cycle after the last.
    for (int i = 0; i < 14; i++) run_op(vecs[i], i);

    // Extra start while busy is ignored; busy length and result unchanged.
    allow_understall = 1'b1;
    bus.start = 1'b1; bus.xaluop = XALU_MULT; bus.a = 32'd3; bus.b = 32'd4;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    @(negedge clk); n++;
    bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd5;
    @(negedge clk); n++;
    bus.start = 1'b0;
    while (bus.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("ignore busy_cycles", 32'(n - 1), 32'd5);
    chk("ignore hi", bus.hi, 32'h0);
    chk("ignore lo", bus.lo, 32'd12);

    // Reset at busy cycle 3 aborts the op immediately.
    bus.start = 1'b1; bus.xaluop = XALU_MULT; bus.a = 32'd6; bus.b = 32'd7;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pre_rst busy", 32'(bus.busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst busy", 32'(bus.busy), 32'h0);
    chk("async_rst hi", bus.hi, 32'h0);
    chk("async_rst lo", bus.lo, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    allow_understall = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst busy", 32'(bus.busy), 32'h0);
    chk("post_rst hi", bus.hi, 32'h0);
    chk("post_rst lo", bus.lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide responder for the P6 five-stage pipeline. It sits in the E stage beside the ALU and answers the datapath's start request with a busy indication. It owns the HI and LO architectural registers and serves MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. The hazard controller stalls decode on busy or start, so this block never sees a back-to-back multi-cycle request while busy.

## Interface
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU.
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request strobe, qualified by xaluop; sampled on the rising edge.
- xaluop  input  3  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- a  input  32  operand rs (forwarded value).
- b  input  32  operand rt (forwarded value).
- busy  output  1  high while a multiply/divide is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- out  output  32  combinational read port: hi when xaluop=MFHI, lo when xaluop=MFLO, else 0.

## Operation
- Reset state: state IDLE, counter 0, busy 0, hi 0, lo 0, shadow registers 0. out follows xaluop from the zero registers.
- State IDLE:
  - start with op 0–3: latch the operation result into shadow_hi/shadow_lo and load the counter with MULT_CYCLES or DIV_CYCLES. Go to BUSY.
  - start with MTHI: hi<=a at the same edge; stay in IDLE; busy stays 0.
  - start with MTLO: lo<=a at the same edge; stay in IDLE; busy stays 0.
  - start with MFHI/MFLO, or start low: no state change.
- State BUSY:
  - The counter decrements each edge.
  - On the edge where the counter goes 1→0: hi<=shadow_hi, lo<=shadow_lo, return to IDLE.
  - start is ignored in BUSY, including MTHI/MTLO. Under-stall is a controller bug; the bench flags it with an assertion.
- MULT: {hi,lo} = signed(a) × signed(b), full 64-bit product.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV:
  - lo = signed quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - 0x80000000/−1 gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, unsigned remainder to hi.
- Divide by zero (b=0, DIV or DIVU): busy still runs the full DIV_CYCLES; hi and lo keep their pre-request values.
- Operands are captured at the start edge. Later changes on a and b have no effect.
- Reset mid-operation: the operation is aborted at once; busy, hi and lo go to 0, and the shadow result is discarded.

## Timing
- Start sampled at edge E0.
- busy is high for exactly N cycles, from just after E0 through edge E0+N.
- hi/lo update and busy falls at the same edge E0+N.
- The first cycle with busy=0 shows the new hi/lo.
- busy is registered and not combinational from start. The controller ORs start into its stall term itself.
- MTHI/MTLO: hi/lo update at E0; visible in the following cycle.
- A new request may be issued in the first cycle after busy falls, sampled at E0+N+1.
- out is purely combinational from xaluop, hi and lo; there is no internal forwarding of in-flight results.

## Structure
- The shared header holds:
  - xaluop_size=3 and the eight op encodings (`XALU_MULT` … `XALU_MFLO`).
  - start_size=1.
  - md state encodings (IDLE=0, BUSY=1).
- Sub-module md_arith is combinational. It takes op, a and b, and produces res_hi, res_lo and div_zero. It isolates the signed/unsigned product and quotient logic from the FSM/counter in md_unit.
- The counter is width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3:
  - busy high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU on the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2:
  - busy high for 10 cycles.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 gives lo=3, hi=1.
- MTHI a=0x12345678, then MFLO/MFHI:
  - hi=0x12345678 the next cycle, busy never asserts.
  - out=0x12345678 when xaluop=MFHI.
- DIV with b=0 after MTLO 0xAAAA:
  - busy lasts 10 cycles.
  - hi and lo are unchanged afterwards (lo=0xAAAA).
- MULT started, second MULT start pulsed at busy cycle 2, reset asserted at busy cycle 3:
  - The second start is ignored; the busy count is unaffected before reset.
  - Reset drops busy asynchronously, hi=lo=0, and the first result is never committed.
- Back-to-back: MULT, then DIVU issued the first cycle after busy falls. Both complete with the correct results, with 5+10 busy cycles and one idle cycle between them.
